mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one slow_memory port between the I-cache and D-cache miss/writeback
//   interfaces of CHIP, so that a single off-chip memory model can serve both.
//   The arbiter grants one 128-bit block transfer at a time and holds it until
//   the memory returns mem_ready. It sits between the two cache mem_* buses and
//   the memory.
// PARAMETERS
//   ADDR_W  28   block address width (address bits [31:4])
//   DATA_W  128  block data width
// PORTS
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous, active-low reset
//   read_I   in   1       I-side read request, held until ready_I
//   write_I  in   1       I-side write request, held until ready_I
//   addr_I   in   ADDR_W  I-side block address
//   wdata_I  in   DATA_W  I-side write data
//   rdata_I  out  DATA_W  I-side read data, valid while ready_I=1
//   ready_I  out  1       I-side one-cycle completion pulse
//   read_D/write_D/addr_D/wdata_D/rdata_D/ready_D   same as the I-side, for the D-cache
//   mem_read   out  1       to memory: read strobe (registered)
//   mem_write  out  1       to memory: write strobe (registered)
//   mem_addr   out  ADDR_W  to memory: address (registered)
//   mem_wdata  out  DATA_W  to memory: write data (registered)
//   mem_rdata  in   DATA_W  from memory: read data
//   mem_ready  in   1       from memory: one-cycle completion pulse
//   grant      out  2       current owner: 00 none, 01 I, 10 D
// BEHAVIOUR
//   - Reset: state IDLE; mem_read, mem_write, grant, ready_I and ready_D = 0;
//     mem_addr, mem_wdata, rdata_I and rdata_D = 0; last-owner pointer = I.
//   - FSM states: IDLE, BUSY_I, BUSY_D.
//   - IDLE: sample the requests (req_X = read_X | write_X). If no request, stay
//     in IDLE. Otherwise choose a winner, and at the clock edge:
//     - latch the winner's address and data into mem_addr/mem_wdata;
//     - set mem_write = write_X, and set mem_read = read_X & ~write_X
//       (write wins if both are set);
//     - set grant and go to BUSY_X.
//   - BUSY_X: hold all mem_* outputs stable.
//     - ready_X = mem_ready (combinational); the other side's ready stays 0.
//     - rdata_X = mem_rdata when grant=X, else 0.
//     - On the edge where mem_ready=1: clear mem_read, mem_write and grant; go to
//       IDLE; update the last-owner pointer to X.
//   - Every transfer therefore ends with at least one IDLE cycle, with mem
//     strobes low, between back-to-back transfers.
//   - Latency: request seen in cycle t -> mem strobe high in cycle t+1;
//     ready_X is high in the same cycle as mem_ready.
//   - Requests that arrive during BUSY are ignored until IDLE; the requester
//     keeps them asserted.
//   - A requester that drops its request mid-BUSY does not abort the transfer;
//     the transfer completes and ready_X still pulses.
//   - mem_ready while in IDLE is ignored; no ready_X is produced.
//   - Asserting rst_n=0 mid-transfer clears all outputs immediately. The memory
//     transaction is abandoned.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN
//   - Defined: when both sides request in IDLE, the side that is not the
//     last owner wins.
//   - Not defined: fixed priority, D over I. The last-owner pointer is still
//     kept, but it is unused.
// TESTING
//   1. Single read: addr_I=28'h0000010, read_I=1; mem_ready after 4 cycles
//      -> mem_read=1, mem_addr=0x0000010 from cycle 1. ready_I pulses once, and
//      rdata_I = mem_rdata = 128'hDEAD... in that cycle. grant returns to 00.
//   2. Collision: read_I and write_D (addr 0x0000020, wdata 128'h1234) are both
//      asserted in IDLE -> D is served first (both modes, last owner = I after
//      reset) with mem_write=1. After ready_D, one IDLE cycle, then I is served.
//   3. With ARB_ROUND_ROBIN_EN: D and I request continuously for 4 transfers
//      -> grant sequence D, I, D, I. Without the macro -> D, D, D, D while D
//      keeps requesting.
//   4. read_D=1 and write_D=1 together -> mem_write=1 and mem_read=0.
//   5. rst_n pulled low two cycles into BUSY_I -> mem_read, grant and ready_I
//      go to 0 asynchronously, with no ready pulse. After release, the still-
//      asserted read_I is re-granted in the first IDLE cycle.
//   6. mem_ready pulsed while in IDLE with no requests -> ready_I = ready_D = 0,
//      and the state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache miss/writeback ports, the shared
// slow_memory port and the arbiter grant indicator.
// slave  : arbiter view (caches and memory drive it, it drives the rest)
// master : environment view (caches + memory model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read_I;
    logic              write_I;
    logic [ADDR_W-1:0] addr_I;
    logic [DATA_W-1:0] wdata_I;
    logic [DATA_W-1:0] rdata_I;
    logic              ready_I;

    logic              read_D;
    logic              write_D;
    logic [ADDR_W-1:0] addr_D;
    logic [DATA_W-1:0] wdata_D;
    logic [DATA_W-1:0] rdata_D;
    logic              ready_D;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [1:0]        grant;

    modport slave (
        input  read_I, write_I, addr_I, wdata_I,
        output rdata_I, ready_I,
        input  read_D, write_D, addr_D, wdata_D,
        output rdata_D, ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant
    );

    modport master (
        output read_I, write_I, addr_I, wdata_I,
        input  rdata_I, ready_I,
        output read_D, write_D, addr_D, wdata_D,
        input  rdata_D, ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one slow_memory port between the I-cache and the
// D-cache. One 128-bit block transfer is granted at a time and held until the
// memory answers with mem_ready; every transfer is followed by an IDLE cycle.
//
// Build option ARB_ROUND_ROBIN_EN:
//   defined     - on a simultaneous request the side that did not own the
//                 previous transfer wins
//   not defined - fixed priority, D over I
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer; requests sampled, winner latched onto mem_* port
// BUSY_I | I-cache transfer in flight, mem_* held until mem_ready
// BUSY_D | D-cache transfer in flight, mem_* held until mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t            state;
    logic              last_owner;

    logic              req_I;
    logic              req_D;
    logic              pick_d;
    logic              win_read;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Request detection and winner selection for the IDLE decision.
    always_comb begin
        req_I = bus.read_I | bus.write_I;
        req_D = bus.read_D | bus.write_D;
`ifdef ARB_ROUND_ROBIN_EN
        if (req_I && req_D) begin
            pick_d = (last_owner == OWNER_I);
        end else begin
            pick_d = req_D;
        end
`else
        pick_d = req_D;
`endif
        win_read  = pick_d ? bus.read_D  : bus.read_I;
        win_write = pick_d ? bus.write_D : bus.write_I;
        win_addr  = pick_d ? bus.addr_D  : bus.addr_I;
        win_wdata = pick_d ? bus.wdata_D : bus.wdata_I;
    end

    // Arbitration FSM with registered memory-side outputs and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_owner    <= OWNER_I;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.grant     <= GRANT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_I || req_D) begin
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        // A simultaneous read+write is treated as a write.
                        bus.mem_write <= win_write;
                        bus.mem_read  <= win_read & ~win_write;
                        bus.grant     <= pick_d ? GRANT_D : GRANT_I;
                        state         <= pick_d ? BUSY_D : BUSY_I;
                    end else begin
                        // Pointer is only consulted by the round-robin tie-break.
                        last_owner <= last_owner;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.grant     <= GRANT_NONE;
                        last_owner    <= OWNER_I;
                        state         <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.grant     <= GRANT_NONE;
                        last_owner    <= OWNER_D;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.grant     <= GRANT_NONE;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Completion and read data are steered straight from memory to the owner;
    // gating on state drops them instantly on an asynchronous reset.
    always_comb begin
        bus.ready_I = (state == BUSY_I) & bus.mem_ready;
        bus.ready_D = (state == BUSY_D) & bus.mem_ready;
        bus.rdata_I = (bus.grant == GRANT_I) ? bus.mem_rdata : '0;
        bus.rdata_D = (bus.grant == GRANT_D) ? bus.mem_rdata : '0;
    end

endmodule
